arbitro_multiplicador_circular: RTL and testbench
=================================================

Name: arbitro_multiplicador_circular

Overview:
Round-robin controller that shares one multiplicador_circular instance (A 2-bit, B 4-bit, Y 4-bit, flags Z/N/C/V) between NUM_REQ requesters. Each operation runs a valid/ready request handshake, a registered execute cycle and a held response. The response is returned with the requester ID and stays stable until the consumer accepts it. The block sits between the requesting units (ALU sequencer, test drivers) and the shared circular-multiply datapath.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
ID_W, $clog2(NUM_REQ), requester ID width; derived, not overridden.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  NUM_REQ  per-requester request valid.
req_a  in  NUM_REQ x 2  per-requester operand A.
req_b  in  NUM_REQ x 4  per-requester operand B.
req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
resp_valid  out  1  result available.
resp_id  out  ID_W  index of the requester that owns the result.
resp_y  out  4  registered Y of the multiplier.
resp_flags  out  4  registered {Z,N,C,V}.
resp_ready  in  1  consumer accepts the result.
busy  out  1  high in EXEC or RESP.
ops_count  out  CNT_W  completed operations, saturating.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_id=0, resp_y=0, resp_flags=0, busy=0, ops_count=0. Reset in any state discards the in-flight operation; no response is emitted.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first index with req_valid set, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally. All other req_ready bits are 0. If no req_valid is set, all are 0.
  - A handshake is req_valid[g] && req_ready[g] at a clock edge. On it, latch a_q=req_a[g], b_q=req_b[g], id_q=g, then go to EXEC.
- EXEC: the multiplier is driven by a_q/b_q. At the end of the cycle, register Y into resp_y and {Z,N,C,V} into resp_flags, set resp_id=id_q, then go to RESP.
- RESP:
  - resp_valid=1. resp_id, resp_y and resp_flags are held stable until resp_ready is sampled high.
  - On resp_valid && resp_ready: rr_ptr = (id_q+1) mod NUM_REQ, ops_count += 1 (saturating at all-ones), resp_valid drops next cycle, go to IDLE.
- req_ready is 0 in EXEC and RESP. busy = (state != IDLE).
- Latency: handshake at edge T; resp_valid is high in the cycle after edge T+1. With resp_ready held high, a new grant is possible 3 cycles after the previous one.
- A requester that drops req_valid before its grant loses nothing; there is no queueing per requester.
- The rr_ptr update uses explicit mod for NUM_REQ that is not a power of two (e.g. 3 → wraps 2→0).
- The multiplier output is not observable outside the RESP state. Y and flags come only from the registered copy.

Decomposition:
- Package arbitro_mul_pkg holds:
  - constants A_W=2, B_W=4, Y_W=4.
  - typedef enum logic [1:0] {IDLE, EXEC, RESP} estado_t.
  - typedef struct packed {logic z, n, c, v;} flags_t.
- One sub-module: the existing multiplicador_circular, instantiated once with A=a_q, B=b_q.
- Round-robin grant logic stays inline (a function in the package is acceptable).

Test Plan:
1. Reset: hold rst_n=0 with all req_valid=1 → every output is 0, including req_ready=0. Release → req_ready=0001 in the first IDLE cycle.
2. Single request: req_valid=0100, req_a[2]=2'b01, req_b[2]=4'b0101, resp_ready=1 → req_ready=0100 at T; resp_valid=1 after T+1; resp_id=2; resp_y/resp_flags equal a standalone multiplicador_circular driven with A=01, B=0101; ops_count=1.
3. Fairness: all req_valid=1111 continuously, resp_ready=1 → grant order 0,1,2,3,0, one grant every 3 cycles. Never two req_ready bits high at once.
4. Backpressure: resp_ready=0 for 5 cycles during RESP with A=3, B=4'b1001 → resp_* stable for all 5 cycles, req_ready=0. Raise resp_ready → IDLE next cycle, and the next requester after the served one is granted.
5. Reset mid-op: assert rst_n=0 in EXEC → resp_valid never rises, rr_ptr=0, ops_count unchanged from 0 (after prior reset).
6. Saturation and odd count: CNT_W=4, NUM_REQ=3, 17 back-to-back ops → ops_count=4'hF. Grant order wraps 2→0.

Source files
------------

// File: rtl/arbitro_mul_pkg.sv
// Shared types and widths for the round-robin circular-multiplier arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arbitro_mul_pkg;

    localparam int A_W = 2;
    localparam int B_W = 4;
    localparam int Y_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } estado_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/multiplicador_circular.sv
// Circular (mod 2^Y_W) multiply of a 2-bit A by a 4-bit B with Z/N/C/V flags.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
//
// Ports:
//   a     : operand A (unsigned for Y/C, two's complement for V)
//   b     : operand B (unsigned for Y/C, two's complement for V)
//   y     : low Y_W bits of the product (wraps around)
//   flags : z = y is zero, n = y msb, c = unsigned product lost bits,
//           v = signed product does not fit in Y_W bits
module multiplicador_circular
    import arbitro_mul_pkg::*;
(
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [Y_W-1:0] y,
    output flags_t         flags
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0]        prod_u;
    logic signed [P_W-1:0] prod_s;

    always_comb begin
        prod_u = P_W'(a) * P_W'(b);
        prod_s = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});
        y      = prod_u[Y_W-1:0];
        flags.z = (prod_u[Y_W-1:0] == '0);
        flags.n = prod_u[Y_W-1];
        flags.c = |prod_u[P_W-1:Y_W];
        // Signed overflow: the full product differs from the sign extension of its low bits.
        flags.v = (prod_s != {{(P_W-Y_W){prod_s[Y_W-1]}}, prod_s[Y_W-1:0]});
    end

endmodule

// File: rtl/arbitro_multiplicador_circular.sv
// Round-robin arbiter sharing one circular multiplier among NUM_REQ requesters.
// Latency: grant at edge T, registered result valid after edge T+1; 3 cycles per op.
// Backpressure: response held stable until resp_ready; no grants while busy.
//
// Ports:
//   clk, rst_n        : clock (rising) and async active-low reset
//   req_valid/a/b     : per-requester request and operands
//   req_ready         : one-hot (or zero) grant, only in IDLE
//   resp_valid/id/y/flags, resp_ready : held response handshake
//   busy              : operation in flight (EXEC or RESP)
//   ops_count         : completed operations, saturating
module arbitro_multiplicador_circular
    import arbitro_mul_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ),
    parameter  int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0][A_W-1:0]  req_a,
    input  logic [NUM_REQ-1:0][B_W-1:0]  req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    output logic [ID_W-1:0]              resp_id,
    output logic [Y_W-1:0]               resp_y,
    output flags_t                       resp_flags,
    input  logic                         resp_ready,
    output logic                         busy,
    output logic [CNT_W-1:0]             ops_count
);

    estado_t         state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id_q;
    logic [A_W-1:0]  a_q;
    logic [B_W-1:0]  b_q;

    logic [Y_W-1:0]  mul_y;
    flags_t          mul_flags;

    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    int              idx;

    multiplicador_circular u_mul (
        .a     (a_q),
        .b     (b_q),
        .y     (mul_y),
        .flags (mul_flags)
    );

    // Scan from rr_ptr upward with wrap; iterating backwards lets the
    // closest valid requester to rr_ptr be the last (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_W'(idx);
            if (req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Gated by rst_n so no grant is advertised while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state == IDLE) && grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_y     <= '0;
            resp_flags <= '0;
            ops_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        a_q   <= req_a[grant_idx];
                        b_q   <= req_b[grant_idx];
                        id_q  <= grant_idx;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_y     <= mul_y;
                    resp_flags <= mul_flags;
                    resp_id    <= id_q;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        // Explicit wrap keeps non-power-of-two NUM_REQ in range.
                        rr_ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
                        if (ops_count != '1) begin
                            ops_count <= ops_count + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_multiplicador_circular.sv
// Self-checking bench for the round-robin circular-multiplier arbiter.
// Latency: n/a.
// Backpressure: n/a.
module tb_arbitro_multiplicador_circular;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance: NUM_REQ=4, CNT_W=16
    logic [3:0]       req_valid, req_ready;
    logic [3:0][1:0]  req_a;
    logic [3:0][3:0]  req_b;
    logic             resp_valid, resp_ready, busy;
    logic [1:0]       resp_id;
    logic [3:0]       resp_y, resp_flags;
    logic [15:0]      ops_count;

    // Second instance: NUM_REQ=3, CNT_W=4
    logic [2:0]       v3, rdy3;
    logic [2:0][1:0]  a3;
    logic [2:0][3:0]  b3;
    logic             rv3, rr3, busy3;
    logic [1:0]       id3;
    logic [3:0]       y3, f3, ops3;

    arbitro_multiplicador_circular #(.NUM_REQ(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id), .resp_y(resp_y),
        .resp_flags(resp_flags), .resp_ready(resp_ready), .busy(busy), .ops_count(ops_count)
    );

    arbitro_multiplicador_circular #(.NUM_REQ(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_a(a3), .req_b(b3),
        .req_ready(rdy3), .resp_valid(rv3), .resp_id(id3), .resp_y(y3),
        .resp_flags(f3), .resp_ready(rr3), .busy(busy3), .ops_count(ops3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference multiply from plain integer arithmetic.
    task automatic ref_mul(input int a, input int b, output logic [3:0] y, output logic [3:0] f);
        int p, sa, sb, sp;
        logic z, n, c, v;
        p  = a * b;
        y  = 4'(p % 16);
        z  = (p % 16) == 0;
        n  = (p % 16) >= 8;
        c  = p > 15;
        sa = (a >= 2) ? a - 4 : a;
        sb = (b >= 8) ? b - 16 : b;
        sp = sa * sb;
        v  = (sp > 7) || (sp < -8);
        f  = {z, n, c, v};
    endtask

    // Transaction-level model per instance: 0 idle, 1 executing, 2 responding.
    int         m_phase [2];
    int         m_ptr   [2];
    int         m_id    [2];
    int         m_ops   [2];
    int         m_max   [2];
    logic [3:0] m_y     [2];
    logic [3:0] m_f     [2];

    task automatic model_step(input int d, input int n, input logic [7:0] vld,
                              input logic [15:0] af, input logic [31:0] bf, input logic rr,
                              input logic [7:0] o_rdy, input logic o_busy, input logic o_rv,
                              input logic [2:0] o_id, input logic [3:0] o_y, input logic [3:0] o_f,
                              input logic [15:0] o_ops);
        string      p;
        int         g;
        logic [7:0] er;
        p  = (d == 0) ? "n4_" : "n3_";
        g  = -1;
        er = '0;
        if (!rst_n) begin
            m_phase[d] = 0; m_ptr[d] = 0; m_ops[d] = 0;
            chk({p, "rst_req_ready"}, o_rdy, 0);
            chk({p, "rst_busy"}, o_busy, 0);
            chk({p, "rst_resp_valid"}, o_rv, 0);
            chk({p, "rst_resp_id"}, o_id, 0);
            chk({p, "rst_resp_y"}, o_y, 0);
            chk({p, "rst_resp_flags"}, o_f, 0);
            chk({p, "rst_ops_count"}, o_ops, 0);
            return;
        end
        if (m_phase[d] == 0) begin
            for (int k = 0; k < n; k++) begin
                int i;
                i = (m_ptr[d] + k) % n;
                if (g < 0 && vld[i]) g = i;
            end
            if (g >= 0) er[g] = 1'b1;
        end
        chk({p, "req_ready"}, o_rdy, er);
        chk({p, "onehot"}, ($countones(o_rdy) <= 1), 1);
        chk({p, "busy"}, o_busy, (m_phase[d] != 0));
        chk({p, "resp_valid"}, o_rv, (m_phase[d] == 2));
        chk({p, "ops_count"}, o_ops, m_ops[d]);
        if (m_phase[d] == 2) begin
            chk({p, "resp_id"}, o_id, m_id[d]);
            chk({p, "resp_y"}, o_y, m_y[d]);
            chk({p, "resp_flags"}, o_f, m_f[d]);
        end
        case (m_phase[d])
            0: if (g >= 0) begin
                m_id[d] = g;
                ref_mul(int'(af[2*g +: 2]), int'(bf[4*g +: 4]), m_y[d], m_f[d]);
                m_phase[d] = 1;
            end
            1: m_phase[d] = 2;
            default: if (rr) begin
                m_ptr[d] = (m_id[d] + 1) % n;
                if (m_ops[d] < m_max[d]) m_ops[d]++;
                m_phase[d] = 0;
            end
        endcase
    endtask

    // Called just after a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        #1;
        model_step(0, 4, 8'(req_valid), 16'(req_a), 32'(req_b), resp_ready,
                   8'(req_ready), busy, resp_valid, 3'(resp_id), resp_y, resp_flags, ops_count);
        model_step(1, 3, 8'(v3), 16'(a3), 32'(b3), rr3,
                   8'(rdy3), busy3, rv3, 3'(id3), y3, f3, 16'(ops3));
        @(negedge clk);
    endtask

    initial begin
        m_max[0] = 65535;
        m_max[1] = 15;
        for (int d = 0; d < 2; d++) begin
            m_phase[d] = 0; m_ptr[d] = 0; m_id[d] = 0; m_ops[d] = 0;
            m_y[d] = '0; m_f[d] = '0;
        end
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_a      = 8'($urandom);
        req_b      = 16'($urandom);
        resp_ready = 1'b1;
        v3         = 3'b000;
        a3         = 6'($urandom);
        b3         = 12'($urandom);
        rr3        = 1'b1;
        @(negedge clk);

        // Reset held with all requests pending, then release: requester 0 first.
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Now in EXEC: reset discards the operation, pointer returns to 0.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req_valid = 4'b0000;
        repeat (4) step();

        // Single request from requester 2: A=01, B=0101.
        req_valid = 4'b0100;
        req_a[2]  = 2'b01;
        req_b[2]  = 4'b0101;
        step();
        req_valid = 4'b0000;
        repeat (3) step();

        // Backpressure: requester 1 with A=3, B=1001, response held 5 cycles.
        req_valid = 4'b0010;
        req_a[1]  = 2'd3;
        req_b[1]  = 4'b1001;
        step();
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        repeat (6) step();
        resp_ready = 1'b1;
        repeat (2) step();

        // Fairness with everyone requesting.
        repeat (15) step();

        // Randomized traffic.
        repeat (400) begin
            req_valid  = 4'($urandom_range(0, 15));
            req_a      = 8'($urandom);
            req_b      = 16'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = 4'b0000;
        resp_ready = 1'b1;
        repeat (3) step();

        // Three-requester instance: 17 back-to-back ops, counter saturates at 4 bits.
        v3 = 3'b111;
        repeat (17 * 3) step();
        v3 = 3'b000;
        chk("n3_ops_saturated", ops3, 4'hF);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
